imm_decode_stage: RTL and testbench

Registered, parametrised immediate-decode pipeline stage for the RISC-V core. Accepts one 32-bit instruction word per cycle over a valid/ready handshake. Classifies its format from the opcode and emits the sign-extended XLEN-wide immediate with register fields, format code and illegal flag. A two-entry skid buffer gives full throughput under backpressure, and a flush drops in-flight entries on redirect.

---
 rtl/imm_decode_pkg.sv | 41 ++++
 rtl/imm_decode_stage_if.sv | 28 ++
 rtl/imm_gen.sv | 92 +++++++++
 rtl/imm_decode_stage.sv | 90 +++++++++
 tb/tb_imm_decode_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_decode_pkg.sv
// rtl/imm_decode_pkg.sv - opcodes, format codes and entry type for the immediate decode stage
package imm_decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Sized for the widest supported datapath; narrower builds leave the top bits zero.
  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    fmt_e                fmt;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [MAX_XLEN-1:0] pc;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - upstream/downstream handshake bundle of the immediate decode stage
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_rd, out_rs1, out_rs2, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_rd, out_rs1, out_rs2, out_pc, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational opcode classification and immediate extraction
module imm_gen
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] raw;
  logic [31:0] i_imm;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign i_imm    = {{20{instr[31]}}, instr[31:20]};

  // Classify the format and build the 32-bit immediate, already sign-filled up to bit 31
  always_comb begin
    fmt = FMT_ILL;
    raw = '0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP_IMM: begin
          if (!is_shift) begin
            fmt = FMT_I;
            raw = i_imm;
          end else if (RV64) begin
            fmt = FMT_I;
            raw = {26'b0, instr[25:20]};
          end else if (!instr[25]) begin
            // shamt[5] set cannot be encoded on a 32-bit datapath
            fmt = FMT_I;
            raw = {27'b0, instr[24:20]};
          end
        end
        OPC_OP_IMM_32: begin
          if (RV64) begin
            fmt = FMT_I;
            raw = is_shift ? {27'b0, instr[24:20]} : i_imm;
          end
        end
        OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
          fmt = FMT_I;
          raw = i_imm;
        end
        OPC_STORE: begin
          fmt = FMT_S;
          raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          raw = {instr[31:12], 12'b0};
        end
        OPC_JAL: begin
          fmt = FMT_J;
          raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_OP: begin
          fmt = FMT_R;
        end
        OPC_OP_32: begin
          if (RV64) fmt = FMT_R;
        end
        default: begin
          fmt = FMT_ILL;
        end
      endcase
    end
  end

  assign illegal = (fmt == FMT_ILL);

  if (RV64) begin : g_wide
    assign imm = {{(XLEN-32){raw[31]}}, raw};
  end else begin : g_narrow
    assign imm = raw;
  end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate decode stage with two-entry skid buffer and flush
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  imm_decode_stage_if.slave  bus
);

  entry_t          out_q;
  entry_t          skid_q;
  entry_t          dec_e;
  logic            out_valid_q;
  logic            skid_valid_q;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            accept;
  logic            pop;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Pack the decoded instruction into a full-width entry
  always_comb begin
    dec_e                = '0;
    dec_e.imm[XLEN-1:0]  = dec_imm;
    dec_e.fmt            = dec_fmt;
    dec_e.rd             = bus.in_instr[11:7];
    dec_e.rs1            = bus.in_instr[19:15];
    dec_e.rs2            = bus.in_instr[24:20];
    dec_e.pc[XLEN-1:0]   = bus.in_pc;
    dec_e.illegal        = dec_illegal;
  end

  assign bus.in_ready = !skid_valid_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = out_valid_q && bus.out_ready;

  // Output and skid registers: flush wins over pop/accept, order is strictly FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      // accept implies the skid is empty, so nothing older needs to move first
      if (!out_valid_q || pop) begin
        out_q       <= dec_e;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= dec_e;
        skid_valid_q <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm[XLEN-1:0];
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_pc      = out_q.pc[XLEN-1:0];
  assign bus.out_illegal = out_q.illegal;

  if (XLEN < MAX_XLEN) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{out_q.imm[MAX_XLEN-1:XLEN], out_q.pc[MAX_XLEN-1:XLEN]};
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed scoreboard bench for imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;
  import imm_decode_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush32;
  logic flush64;
  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t drv32;
  exp_t drv64;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) bus32();
  imm_decode_stage_if #(.XLEN(64)) bus64();

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush32), .bus(bus32));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush64), .bus(bus64));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_entry(input string pfx, input exp_t e, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [63:0] pc, input logic ill);
    check({pfx, "_imm"}, imm, e.imm);
    check({pfx, "_fmt"}, {61'b0, fmt}, {61'b0, e.fmt});
    check({pfx, "_rd"},  {59'b0, rd},  {59'b0, e.rd});
    check({pfx, "_rs1"}, {59'b0, rs1}, {59'b0, e.rs1});
    check({pfx, "_rs2"}, {59'b0, rs2}, {59'b0, e.rs2});
    check({pfx, "_pc"},  pc, e.pc);
    check({pfx, "_ill"}, {63'b0, ill}, {63'b0, e.ill});
  endtask

  // Scoreboard for the 32-bit stage: retire popped entries, then record accepted ones
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst_n || flush32) begin
      q32.delete();
    end else begin
      if (bus32.out_valid && bus32.out_ready) begin
        checks++;
        assert (q32.size() != 0) else begin
          errors++;
          $error("FAIL sb32_pop: observed unexpected output pc %h, expected no output", bus32.out_pc);
        end
        if (q32.size() != 0) begin
          e = q32.pop_front();
          cmp_entry("sb32", e, {32'b0, bus32.out_imm}, bus32.out_fmt, bus32.out_rd,
                    bus32.out_rs1, bus32.out_rs2, {32'b0, bus32.out_pc}, bus32.out_illegal);
        end
      end
      if (bus32.in_valid && bus32.in_ready) q32.push_back(drv32);
    end
  end

  // Scoreboard for the 64-bit stage
  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst_n || flush64) begin
      q64.delete();
    end else begin
      if (bus64.out_valid && bus64.out_ready) begin
        checks++;
        assert (q64.size() != 0) else begin
          errors++;
          $error("FAIL sb64_pop: observed unexpected output pc %h, expected no output", bus64.out_pc);
        end
        if (q64.size() != 0) begin
          e = q64.pop_front();
          cmp_entry("sb64", e, bus64.out_imm, bus64.out_fmt, bus64.out_rd,
                    bus64.out_rs1, bus64.out_rs2, bus64.out_pc, bus64.out_illegal);
        end
      end
      if (bus64.in_valid && bus64.in_ready) q64.push_back(drv64);
    end
  end

  task automatic set32(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [63:0] imm, input logic [2:0] fmt);
    bus32.in_valid = v;
    bus32.in_instr = instr;
    bus32.in_pc    = pc;
    drv32 = '{imm, fmt, instr[11:7], instr[19:15], instr[24:20], {32'b0, pc}, (fmt == 3'd7)};
  endtask

  task automatic set64(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [2:0] fmt);
    bus64.in_valid = v;
    bus64.in_instr = instr;
    bus64.in_pc    = pc;
    drv64 = '{imm, fmt, instr[11:7], instr[19:15], instr[24:20], pc, (fmt == 3'd7)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [63:0] imm, input logic [2:0] fmt);
    set32(1'b1, instr, pc, imm, fmt);
    tick();
    check("lat32", {63'b0, bus32.out_valid}, 64'd1);
  endtask

  task automatic send64(input logic [31:0] instr, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [2:0] fmt);
    set64(1'b1, instr, pc, imm, fmt);
    tick();
    check("lat64", {63'b0, bus64.out_valid}, 64'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush32 = 1'b0;
    flush64 = 1'b0;
    bus32.out_ready = 1'b0;
    bus64.out_ready = 1'b0;
    set32(1'b0, 32'h0, 32'h0, 64'h0, 3'd0);
    set64(1'b0, 32'h0, 64'h0, 64'h0, 3'd0);

    #2;
    check("rst_out_valid32", {63'b0, bus32.out_valid}, 64'd0);
    check("rst_in_ready32", {63'b0, bus32.in_ready}, 64'd1);
    check("rst_imm32", {32'b0, bus32.out_imm}, 64'd0);
    check("rst_fmt32", {61'b0, bus32.out_fmt}, 64'd0);
    check("rst_ill32", {63'b0, bus32.out_illegal}, 64'd0);
    check("rst_out_valid64", {63'b0, bus64.out_valid}, 64'd0);
    check("rst_in_ready64", {63'b0, bus64.in_ready}, 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back stream without backpressure
    bus32.out_ready = 1'b1;
    tick();
    send32(32'hFFF00093, 32'h1000, 64'hFFFF_FFFF, FMT_I);
    send32(32'hFE112E23, 32'h1004, 64'hFFFF_FFFC, FMT_S);
    send32(32'h001000EF, 32'h1008, 64'h0000_0800, FMT_J);
    send32(32'h123452B7, 32'h100C, 64'h1234_5000, FMT_U);
    send32(32'hFE000EE3, 32'h1010, 64'hFFFF_FFFC, FMT_B);
    send32(32'h002081B3, 32'h1014, 64'h0, FMT_R);
    send32(32'h02009093, 32'h1018, 64'h0, FMT_ILL);
    send32(32'h0000001B, 32'h101C, 64'h0, FMT_ILL);
    send32(32'h00000001, 32'h1020, 64'h0, FMT_ILL);
    send32(32'h0000003B, 32'h1024, 64'h0, FMT_ILL);
    set32(1'b0, 32'h0, 32'h0, 64'h0, 3'd0);
    tick();
    check("drain32", {63'b0, bus32.out_valid}, 64'd0);

    // Backpressure: A in output, B in skid, C held off
    bus32.out_ready = 1'b0;
    set32(1'b1, 32'h00500113, 32'h2000, 64'd5, FMT_I);
    tick();
    check("bp_a_valid", {63'b0, bus32.out_valid}, 64'd1);
    set32(1'b1, 32'h00A00193, 32'h2004, 64'd10, FMT_I);
    tick();
    check("bp_in_ready_b", {63'b0, bus32.in_ready}, 64'd0);
    check("bp_hold_a", {32'b0, bus32.out_pc}, 64'h2000);
    set32(1'b1, 32'h00F00213, 32'h2008, 64'd15, FMT_I);
    tick();
    check("bp_in_ready_c", {63'b0, bus32.in_ready}, 64'd0);
    check("bp_stable_a", {32'b0, bus32.out_imm}, 64'd5);
    bus32.out_ready = 1'b1;
    tick();
    check("bp_order_b", {32'b0, bus32.out_pc}, 64'h2004);
    check("bp_ready_again", {63'b0, bus32.in_ready}, 64'd1);
    tick();
    check("bp_order_c", {32'b0, bus32.out_pc}, 64'h2008);
    set32(1'b0, 32'h0, 32'h0, 64'h0, 3'd0);
    tick();
    check("bp_drain", {63'b0, bus32.out_valid}, 64'd0);

    // Flush with both entries full and a new offer in the same cycle
    bus32.out_ready = 1'b0;
    set32(1'b1, 32'h00100293, 32'h3000, 64'd1, FMT_I);
    tick();
    set32(1'b1, 32'h00200313, 32'h3004, 64'd2, FMT_I);
    tick();
    set32(1'b1, 32'h00300393, 32'h3008, 64'd3, FMT_I);
    flush32 = 1'b1;
    tick();
    flush32 = 1'b0;
    set32(1'b0, 32'h0, 32'h0, 64'h0, 3'd0);
    check("flush_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    check("flush_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    bus32.out_ready = 1'b1;
    repeat (3) tick();
    check("flush_no_ghost", {63'b0, bus32.out_valid}, 64'd0);

    // Asynchronous reset between edges while an entry is held
    bus32.out_ready = 1'b0;
    set32(1'b1, 32'h7FF00413, 32'h4000, 64'h7FF, FMT_I);
    tick();
    check("rst_mid_loaded", {63'b0, bus32.out_valid}, 64'd1);
    set32(1'b0, 32'h0, 32'h0, 64'h0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    check("arst_imm", {32'b0, bus32.out_imm}, 64'd0);
    check("arst_pc", {32'b0, bus32.out_pc}, 64'd0);
    check("arst_rd", {59'b0, bus32.out_rd}, 64'd0);
    check("arst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    set32(1'b1, 32'h00C00493, 32'h5000, 64'd12, FMT_I);
    tick();
    check("post_rst_valid", {63'b0, bus32.out_valid}, 64'd1);
    check("post_rst_pc", {32'b0, bus32.out_pc}, 64'h5000);
    set32(1'b0, 32'h0, 32'h0, 64'h0, 3'd0);
    tick();
    check("post_rst_drain", {63'b0, bus32.out_valid}, 64'd0);

    // 64-bit datapath
    bus64.out_ready = 1'b1;
    send64(32'h800002B7, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000, FMT_U);
    send64(32'h02009093, 64'h0000_0001_0000_0004, 64'd32, FMT_I);
    send64(32'h0000001B, 64'h0000_0001_0000_0008, 64'd0, FMT_I);
    send64(32'h0000003B, 64'h0000_0001_0000_000C, 64'd0, FMT_R);
    send64(32'hFFF00093, 64'h8000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    send64(32'h001000EF, 64'h0000_0001_0000_0014, 64'h800, FMT_J);
    send64(32'h00000001, 64'h0000_0001_0000_0018, 64'd0, FMT_ILL);
    set64(1'b0, 32'h0, 64'h0, 64'h0, 3'd0);
    tick();
    check("drain64", {63'b0, bus64.out_valid}, 64'd0);

    repeat (2) tick();
    check("sb32_empty", 64'(q32.size()), 64'd0);
    check("sb64_empty", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
